// File: rtl/anton_neopixel_bus_arbiter_if.sv
// Requester handshakes and the neopixel register bus, bundled for the arbiter
// (slave view) and the surrounding masters/neopixel module (master view).
interface anton_neopixel_bus_arbiter_if;
    logic        aValid;
    logic        aWrite;
    logic [13:0] aAddr;
    logic [7:0]  aData;
    logic        aReady;
    logic        aRspValid;
    logic [7:0]  aRspData;
    logic        aRspErr;

    logic        bValid;
    logic        bWrite;
    logic [13:0] bAddr;
    logic [7:0]  bData;
    logic        bReady;
    logic        bRspValid;
    logic [7:0]  bRspData;
    logic        bRspErr;

    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataOut;

    modport slave (
        input  aValid, aWrite, aAddr, aData,
        output aReady, aRspValid, aRspData, aRspErr,
        input  bValid, bWrite, bAddr, bData,
        output bReady, bRspValid, bRspData, bRspErr,
        output busAddr, busDataIn, busWrite, busRead,
        input  busDataOut
    );

    modport master (
        output aValid, aWrite, aAddr, aData,
        input  aReady, aRspValid, aRspData, aRspErr,
        output bValid, bWrite, bAddr, bData,
        input  bReady, bRspValid, bRspData, bRspErr,
        input  busAddr, busDataIn, busWrite, busRead,
        output busDataOut
    );
endinterface

// File: rtl/anton_neopixel_bus_arbiter.sv
// Round-robin arbiter sharing the neopixel 8-bit register bus between requester A
// (CPU/MSS) and requester B (frame upload); one single-access transaction at a time.
module anton_neopixel_bus_arbiter #(
    parameter logic [13:0] ADDR_MAX     = 14'h3FFF,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                         busClk,
    input  logic                         busReset,
    anton_neopixel_bus_arbiter_if.slave  bif,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_t;

    localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 1);

    state_t      state_q;
    req_t        rr_last_q;
    req_t        owner_q;
    logic        write_q;
    logic [3:0]  wait_cnt_q;
    logic        busy_q;

    logic [13:0] bus_addr_q;
    logic [7:0]  bus_wdata_q;
    logic        bus_write_q;
    logic        bus_read_q;

    logic        a_rsp_valid_q;
    logic        a_rsp_err_q;
    logic [7:0]  a_rsp_data_q;
    logic        b_rsp_valid_q;
    logic        b_rsp_err_q;
    logic [7:0]  b_rsp_data_q;

    logic        grant_a;
    logic        grant_b;
    logic        accept;
    req_t        win_id;
    logic        win_is_a;
    logic        win_write;
    logic [13:0] win_addr;
    logic [7:0]  win_data;
    logic        win_err;
    logic        owner_is_a;

    // On a tie the requester that did not win last time gets the bus.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == IDLE) begin
            grant_a = bif.aValid & (~bif.bValid | (rr_last_q == REQ_B));
            grant_b = bif.bValid & (~bif.aValid | (rr_last_q == REQ_A));
        end
        accept     = grant_a | grant_b;
        win_id     = grant_b ? REQ_B : REQ_A;
        win_is_a   = ~grant_b;
        win_write  = grant_b ? bif.bWrite : bif.aWrite;
        win_addr   = grant_b ? bif.bAddr  : bif.aAddr;
        win_data   = grant_b ? bif.bData  : bif.aData;
        win_err    = (win_addr > ADDR_MAX);
        owner_is_a = (owner_q == REQ_A);
    end

    always_ff @(posedge busClk or posedge busReset) begin
        if (busReset) begin
            state_q       <= IDLE;
            rr_last_q     <= REQ_B;
            owner_q       <= REQ_A;
            write_q       <= 1'b0;
            wait_cnt_q    <= '0;
            busy_q        <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_write_q   <= 1'b0;
            bus_read_q    <= 1'b0;
            a_rsp_valid_q <= 1'b0;
            a_rsp_err_q   <= 1'b0;
            a_rsp_data_q  <= '0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_err_q   <= 1'b0;
            b_rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rr_last_q <= win_id;
                        owner_q   <= win_id;
                        write_q   <= win_write;
                        busy_q    <= 1'b1;
                        // Out-of-range requests answer straight away and leave the bus untouched.
                        if (win_err) begin
                            state_q       <= DONE;
                            a_rsp_valid_q <= win_is_a;
                            a_rsp_err_q   <= win_is_a;
                            b_rsp_valid_q <= ~win_is_a;
                            b_rsp_err_q   <= ~win_is_a;
                        end else begin
                            state_q     <= ACCESS;
                            bus_addr_q  <= win_addr;
                            bus_wdata_q <= win_data;
                            bus_write_q <= win_write;
                            bus_read_q  <= ~win_write;
                        end
                    end
                end
                ACCESS: begin
                    bus_write_q <= 1'b0;
                    bus_read_q  <= 1'b0;
                    if (write_q) begin
                        state_q       <= DONE;
                        a_rsp_valid_q <= owner_is_a;
                        b_rsp_valid_q <= ~owner_is_a;
                    end else begin
                        state_q    <= WAIT;
                        wait_cnt_q <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q       <= DONE;
                        a_rsp_valid_q <= owner_is_a;
                        b_rsp_valid_q <= ~owner_is_a;
                        a_rsp_data_q  <= owner_is_a ? bif.busDataOut : '0;
                        b_rsp_data_q  <= owner_is_a ? '0 : bif.busDataOut;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    a_rsp_valid_q <= 1'b0;
                    a_rsp_err_q   <= 1'b0;
                    a_rsp_data_q  <= '0;
                    b_rsp_valid_q <= 1'b0;
                    b_rsp_err_q   <= 1'b0;
                    b_rsp_data_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bif.aReady    = grant_a;
    assign bif.bReady    = grant_b;
    assign bif.aRspValid = a_rsp_valid_q;
    assign bif.aRspErr   = a_rsp_err_q;
    assign bif.aRspData  = a_rsp_data_q;
    assign bif.bRspValid = b_rsp_valid_q;
    assign bif.bRspErr   = b_rsp_err_q;
    assign bif.bRspData  = b_rsp_data_q;
    assign bif.busAddr   = bus_addr_q;
    assign bif.busDataIn = bus_wdata_q;
    assign bif.busWrite  = bus_write_q;
    assign bif.busRead   = bus_read_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// Bench for the neopixel bus arbiter: scoreboarded directed sequence on a
// READ_LATENCY=1 / ADDR_MAX=0x1FFF instance, plus a cycle table on a READ_LATENCY=3 instance.
module tb_anton_neopixel_bus_arbiter;

    localparam int unsigned RL0   = 1;
    localparam logic [13:0] AMAX0 = 14'h1FFF;

    typedef struct {
        bit          is_b;
        logic [7:0]  data;
        logic        err;
        int unsigned cyc;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [13:0] addr;
        logic [7:0]  data;
        int unsigned cyc;
    } bus_t;

    typedef struct {
        bit          is_b;
        int unsigned cyc;
    } gnt_t;

    logic busClk = 1'b0;
    logic rst0;
    logic rst1;
    logic busy0;
    logic busy1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int unsigned cyc = 0;

    rsp_t sb_rsp[$];
    bus_t sb_bus[$];
    gnt_t glog[$];
    rsp_t mon_rsp;
    bus_t mon_bus;

    logic [7:0] wmem [logic [13:0]];
    logic [7:0] pipe0;
    logic [7:0] pipe1 [3];

    always #5 busClk = ~busClk;
    always @(posedge busClk) cyc <= cyc + 1;

    anton_neopixel_bus_arbiter_if if0 ();
    anton_neopixel_bus_arbiter_if if1 ();

    anton_neopixel_bus_arbiter #(
        .ADDR_MAX     (AMAX0),
        .READ_LATENCY (RL0)
    ) dut0 (
        .busClk   (busClk),
        .busReset (rst0),
        .bif      (if0),
        .busy     (busy0)
    );

    anton_neopixel_bus_arbiter #(
        .ADDR_MAX     (14'h3FFF),
        .READ_LATENCY (3)
    ) dut1 (
        .busClk   (busClk),
        .busReset (rst1),
        .bif      (if1),
        .busy     (busy1)
    );

    function automatic logic [7:0] rd0(input logic [13:0] ad);
        if (wmem.exists(ad)) return wmem[ad];
        if (ad == 14'h0004) return 8'h3C;
        return ad[7:0] ^ 8'h5A;
    endfunction

    // Neopixel register file behind dut0; 0xEE marks cycles with no valid read data.
    always @(posedge busClk) begin
        pipe0 <= (if0.busRead === 1'b1) ? rd0(if0.busAddr) : 8'hEE;
        if (if0.busWrite === 1'b1) wmem[if0.busAddr] = if0.busDataIn;
    end
    assign if0.busDataOut = pipe0;

    always @(posedge busClk) begin
        pipe1[0] <= (if1.busRead === 1'b1) ? (if1.busAddr[7:0] ^ 8'hC3) : 8'hEE;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign if1.busDataOut = pipe1[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] outs0();
        return {if0.aReady, if0.bReady, if0.aRspValid, if0.aRspData, if0.aRspErr,
                if0.bRspValid, if0.bRspData, if0.bRspErr, if0.busAddr, if0.busDataIn,
                if0.busWrite, if0.busRead, busy0};
    endfunction

    function automatic logic [47:0] outs1();
        return {if1.aReady, if1.bReady, if1.aRspValid, if1.aRspData, if1.aRspErr,
                if1.bRspValid, if1.bRspData, if1.bRspErr, if1.busAddr, if1.busDataIn,
                if1.busWrite, if1.busRead, busy1};
    endfunction

    task automatic push_acc(input bit is_b, input logic w, input logic [13:0] ad, input logic [7:0] d);
        rsp_t r;
        bus_t b;
        gnt_t g;
        r.is_b = is_b;
        r.err  = (ad > AMAX0);
        r.data = (w || r.err) ? 8'h00 : rd0(ad);
        r.cyc  = cyc + (r.err ? 1 : (w ? 2 : 2 + RL0));
        sb_rsp.push_back(r);
        if (!r.err) begin
            b.wr = w; b.addr = ad; b.data = d; b.cyc = cyc + 1;
            sb_bus.push_back(b);
        end
        g.is_b = is_b; g.cyc = cyc;
        glog.push_back(g);
    endtask

    // Scoreboard monitor for dut0.
    always @(negedge busClk) begin
        if (rst0 === 1'b0) begin
            if ((if0.aReady | if0.bReady) === 1'b1)
                check("ready_exclusive", if0.aReady & if0.bReady, 1'b0);
            if ((if0.aValid & if0.aReady) === 1'b1) push_acc(1'b0, if0.aWrite, if0.aAddr, if0.aData);
            if ((if0.bValid & if0.bReady) === 1'b1) push_acc(1'b1, if0.bWrite, if0.bAddr, if0.bData);
            if ((if0.busWrite | if0.busRead) === 1'b1) begin
                if (sb_bus.size() == 0) begin
                    check("bus_unexpected", {if0.busWrite, if0.busRead}, 2'b00);
                end else begin
                    mon_bus = sb_bus.pop_front();
                    check("bus_op", {if0.busWrite, if0.busRead, if0.busAddr, if0.busDataIn, cyc},
                          {mon_bus.wr, ~mon_bus.wr, mon_bus.addr, mon_bus.data, mon_bus.cyc});
                end
            end
            if ((if0.aRspValid | if0.bRspValid) === 1'b1) begin
                if (sb_rsp.size() == 0) begin
                    check("rsp_unexpected", {if0.aRspValid, if0.bRspValid}, 2'b00);
                end else begin
                    mon_rsp = sb_rsp.pop_front();
                    if (mon_rsp.is_b)
                        check("rsp_b", {if0.aRspValid, if0.bRspValid, if0.bRspData, if0.bRspErr,
                                        if0.aRspData, if0.aRspErr, cyc},
                              {2'b01, mon_rsp.data, mon_rsp.err, 9'h000, mon_rsp.cyc});
                    else
                        check("rsp_a", {if0.aRspValid, if0.bRspValid, if0.aRspData, if0.aRspErr,
                                        if0.bRspData, if0.bRspErr, cyc},
                              {2'b10, mon_rsp.data, mon_rsp.err, 9'h000, mon_rsp.cyc});
                end
            end
        end
    end

    task automatic drive0(input bit is_b, input logic v, input logic w, input logic [13:0] ad, input logic [7:0] d);
        if (is_b) begin
            if0.bValid = v; if0.bWrite = w; if0.bAddr = ad; if0.bData = d;
        end else begin
            if0.aValid = v; if0.aWrite = w; if0.aAddr = ad; if0.aData = d;
        end
    endtask

    // Returns #1 after the accepting edge.
    task automatic wait_acc0(input bit is_b);
        int unsigned n;
        n = 0;
        do begin
            @(negedge busClk);
            n++;
        end while (((is_b ? if0.bReady : if0.aReady) !== 1'b1) && n < 40);
        if ((is_b ? if0.bReady : if0.aReady) !== 1'b1)
            check("accept_timeout", is_b ? if0.bReady : if0.aReady, 1'b1);
        @(posedge busClk);
        #1;
    endtask

    task automatic stream0(input bit is_b, input int unsigned cnt, input logic w, input logic [13:0] base);
        @(posedge busClk);
        #1;
        for (int unsigned i = 0; i < cnt; i++) begin
            drive0(is_b, 1'b1, w, base + 14'(i), base[7:0] ^ 8'(i * 17));
            wait_acc0(is_b);
        end
        drive0(is_b, 1'b0, 1'b0, 14'h0000, 8'h00);
    endtask

    task automatic drain0();
        int unsigned n;
        n = 0;
        while ((sb_rsp.size() != 0 || sb_bus.size() != 0) && n < 40) begin
            @(negedge busClk);
            n++;
        end
        check("drain_rsp", sb_rsp.size(), 0);
        check("drain_bus", sb_bus.size(), 0);
        repeat (2) @(negedge busClk);
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        #1;
        sb_rsp.delete();
        sb_bus.delete();
        glog.delete();
        check("reset_outputs0", outs0(), '0);
        repeat (2) @(posedge busClk);
        #1 rst0 = 1'b0;
    endtask

    task automatic contest_first_a(input string tag);
        fork
            stream0(1'b0, 1, 1'b1, 14'h0300);
            stream0(1'b1, 1, 1'b1, 14'h0380);
        join
        drain0();
        check({tag, "_count"}, glog.size(), 2);
        if (glog.size() >= 2) begin
            check({tag, "_first"}, glog[0].is_b, 1'b0);
            check({tag, "_second"}, glog[1].is_b, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] t6_addr;
        if0.aValid = 0; if0.aWrite = 0; if0.aAddr = '0; if0.aData = '0;
        if0.bValid = 0; if0.bWrite = 0; if0.bAddr = '0; if0.bData = '0;
        if1.aValid = 0; if1.aWrite = 0; if1.aAddr = '0; if1.aData = '0;
        if1.bValid = 0; if1.bWrite = 0; if1.bAddr = '0; if1.bData = '0;
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        #1;
        check("reset_outputs0_init", outs0(), '0);
        check("reset_outputs1_init", outs1(), '0);
        repeat (2) @(posedge busClk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge busClk);
        check("idle_outputs0", outs0(), '0);

        // 1: A write, B idle
        stream0(1'b0, 1, 1'b1, 14'h0010);
        drain0();
        check("mem_after_write", wmem.exists(14'h0010) ? wmem[14'h0010] : 8'h00, 8'h10);

        // 2: B read of 0x0004 returning 0x3C
        stream0(1'b1, 1, 1'b0, 14'h0004);
        drain0();

        // 3: both streaming writes from reset
        @(posedge busClk);
        #1;
        reset0();
        fork
            stream0(1'b0, 4, 1'b1, 14'h0100);
            stream0(1'b1, 4, 1'b1, 14'h0200);
        join
        drain0();
        check("rr_count", glog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < glog.size()) begin
                check("rr_order", glog[i].is_b, i[0]);
                if (i > 0) check("rr_spacing", glog[i].cyc - glog[i-1].cyc, 3);
            end
        end

        // 4: address boundary and error paths
        stream0(1'b0, 1, 1'b1, 14'h2000);
        stream0(1'b0, 1, 1'b0, 14'h1FFF);
        stream0(1'b1, 1, 1'b0, 14'h3FFF);
        stream0(1'b0, 1, 1'b0, 14'h0100);
        drain0();

        // 5: reset during WAIT of a B read
        @(posedge busClk);
        #1;
        drive0(1'b1, 1'b1, 1'b0, 14'h0008, 8'h00);
        wait_acc0(1'b1);
        drive0(1'b1, 1'b0, 1'b0, 14'h0000, 8'h00);
        check("t5_busRead_access", if0.busRead, 1'b1);
        @(posedge busClk);
        #1;
        check("t5_busy_wait", busy0, 1'b1);
        reset0();
        repeat (6) @(negedge busClk);
        contest_first_a("t5_contest");
        stream0(1'b0, 1, 1'b1, 14'h0040);
        drain0();
        @(posedge busClk);
        #1;
        reset0();
        contest_first_a("t5_rrlast_reset");

        // 6: READ_LATENCY=3 instance, A reads while B waits
        t6_addr = 14'h3FFF;
        @(posedge busClk);
        #1;
        if1.aValid = 1'b1; if1.aWrite = 1'b0; if1.aAddr = t6_addr; if1.aData = 8'h00;
        if1.bValid = 1'b1; if1.bWrite = 1'b1; if1.bAddr = 14'h0100; if1.bData = 8'h99;
        @(negedge busClk);
        check("t6_ready_k0", {if1.aReady, if1.bReady}, 2'b10);
        @(posedge busClk);
        #1;
        if1.aValid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge busClk);
            check("t6_busRead", if1.busRead, (k == 1));
            check("t6_busWrite", if1.busWrite, (k == 7));
            check("t6_bReady", if1.bReady, (k == 6));
            check("t6_aRspValid", if1.aRspValid, (k == 5));
            check("t6_bRspValid", if1.bRspValid, (k == 8));
            if (k == 5) check("t6_aRspData", {if1.aRspData, if1.aRspErr}, {t6_addr[7:0] ^ 8'hC3, 1'b0});
            if (k == 7) check("t6_bus_wr", {if1.busAddr, if1.busDataIn}, {14'h0100, 8'h99});
            if (k == 6) begin
                @(posedge busClk);
                #1;
                if1.bValid = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
